md_sequencer: RTL

Multi-cycle multiply/divide controller for the MIPS ALU. It takes MULT/MULTU/DIV/DIVU requests from the decode/execute stage and sequences a shared shift-add/restoring-subtract datapath over WIDTH iterations. Results land in architectural HI/LO registers. busy_o stalls the pipeline, and MTHI/MTLO writes are arbitrated against in-flight operations.

---
 rtl/md_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// Multi-cycle MIPS multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over WIDTH iterations, with results written to HI/LO.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             cancel_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic               op_div, neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   opnd, acc_hi, acc_lo;
    logic               accept, finish, sgn_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign busy_o = (state != IDLE);
    assign accept = (state == IDLE) && start_i;
    // cancel wins over completion in the FIXUP cycle
    assign finish = (state == FIXUP) && !cancel_i;
    assign sgn_in = ~op_i[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = CALC;
            CALC: begin
                if (cancel_i)           state_nxt = IDLE;
                else if (count == '0)   state_nxt = FIXUP;
            end
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One radix-2 iteration: acc_hi holds partial product / remainder,
    // acc_lo holds the multiplier being shifted out / quotient being shifted in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = cond_neg_wide({acc_hi, acc_lo}, neg_a ^ neg_b);
        if (op_div) begin
            res_hi = cond_neg(acc_hi, neg_a);
            res_lo = div_zero ? '1 : cond_neg(acc_lo, neg_a ^ neg_b);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count    <= '0;
            op_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            done_o <= finish;
            if (accept) begin
                op_div   <= op_i[1];
                neg_a    <= sgn_in & in1_i[WIDTH-1];
                neg_b    <= sgn_in & in2_i[WIDTH-1];
                div_zero <= (in2_i == '0);
                acc_hi   <= '0;
                acc_lo   <= op_i[1] ? magnitude(in1_i, sgn_in) : magnitude(in2_i, sgn_in);
                opnd     <= op_i[1] ? magnitude(in2_i, sgn_in) : magnitude(in1_i, sgn_in);
                count    <= CNT_LAST;
            end else if (state == CALC) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - 1'b1;
            end
            if (finish) begin
                hi_o <= res_hi;
                lo_o <= res_lo;
            end else if (state == IDLE) begin
                if (wr_hi_i) hi_o <= wr_data_i;
                if (wr_lo_i) lo_o <= wr_data_i;
            end
        end
    end

endmodule
